snake_game_seq: RTL and testbench
=================================

Name: snake_game_seq

Overview:
- Parametrised game sequencer for the snake game. Replaces the single ad-hoc game_over latch and fixed-rate step gating with a full state machine covering start, countdown, run, pause, death animation, lives and game over.
- Also owns speed levels: the move step rate rises as apples are eaten.
- Sits between a fixed-rate base tick generator and the snake core, apple and score blocks. Drives the gated move step, a soft restart pulse and status for the renderer.

Parameters:
- LIVES, 3, lives at game start (1..15)
- DIV_START, 10, base ticks per move step at level 0 (2..255)
- DIV_STEP, 1, step-period reduction per level
- DIV_MIN, 3, minimum base ticks per move step (1..DIV_START)
- APPLES_PER_LEVEL, 4, eat events per level-up (1..255)
- MAX_LEVEL, 7, level saturation value (0..15)
- READY_TICKS, 8, base ticks of countdown before RUN
- DIE_TICKS, 10, base ticks of death animation

Ports:
- clk_pix  in  1  pixel clock; only clock
- reset  in  1  synchronous, active-high reset
- base_tick  in  1  one-cycle pulse from fixed-rate tick generator
- start_btn  in  1  one-cycle debounced start pulse
- pause_btn  in  1  one-cycle debounced pause pulse
- eat_evt  in  1  one-cycle apple-eaten pulse
- self_hit  in  1  snake head on body
- wall_hit  in  1  snake head on border
- step  out  1  one-cycle gated move pulse to snake core
- soft_reset  out  1  one-cycle pulse re-initialising snake, apple, score
- state  out  3  IDLE=0 READY=1 RUN=2 PAUSE=3 DYING=4 OVER=5
- lives  out  4  remaining lives
- level  out  4  current speed level
- blink  out  1  renderer flash enable
- game_over  out  1  high in OVER

Behaviour:
- Reset (sync, active-high) puts all outputs at these values: state=IDLE, lives=LIVES, level=0, step=0, soft_reset=0, blink=0, game_over=0. Reset also clears the internal divider, apple count and tick counters. Reset asserted mid-game returns the block to IDLE on the next edge.
- Step period P = max(DIV_START - level*DIV_STEP, DIV_MIN), computed in 9-bit unsigned with no underflow: the term clamps to DIV_MIN.
- IDLE:
  - start_btn: lives<=LIVES, level<=0, apple count<=0, soft_reset=1 for exactly one cycle (registered, asserted the cycle after start_btn), then go to READY.
- READY:
  - Count base_tick. blink toggles on each base_tick.
  - After READY_TICKS base ticks go to RUN, with blink=0 and divider=0. No step is issued in READY.
- RUN:
  - The divider counts base_tick. The base_tick that brings the count to P asserts step in the following cycle and clears the divider.
  - step is never high outside RUN.
  - eat_evt increments the apple count. When the count reaches APPLES_PER_LEVEL it clears and level increments, saturating at MAX_LEVEL. The new P applies from the next step period.
  - self_hit|wall_hit, sampled every cycle, causes:
    - transition to DYING;
    - lives decrement, saturating at 0;
    - any step pending in the same cycle is suppressed.
  - Simultaneous hit and eat_evt: the hit wins and the eat is ignored.
  - Simultaneous hit and pause_btn: the hit wins.
- PAUSE:
  - Divider, counters and level are frozen. Hits and eat_evt are ignored.
  - pause_btn or start_btn returns to RUN, with the divider value preserved.
- DYING:
  - blink toggles per base_tick.
  - After DIE_TICKS base ticks:
    - lives==0: go to OVER.
    - otherwise: pulse soft_reset once and go to READY. Level and apple count are retained.
- OVER:
  - game_over=1, blink=0.
  - start_btn behaves exactly as in IDLE.
- base_tick during any cycle in which start_btn or pause_btn acts is still counted by the destination state only from the next cycle.
- Undefined state encodings recover to IDLE.

Optional Feature:
- SNAKE_PAUSE_EN
  - Defined: PAUSE state and pause_btn behave as above.
  - Undefined: pause_btn is ignored everywhere, PAUSE is unreachable, and state never reads 3.

Test Plan:
- Reset, then start_btn in IDLE -> soft_reset high exactly 1 cycle, state=1. After 8 base_ticks, state=2 and lives=3, level=0.
- RUN at level 0 with base_tick every 4 cycles -> step every 40 cycles (P=10). Exactly 4 eat_evt -> level=1, next period 9 base ticks. After 28 eats, level=7 and P=3 (clamped). A further 4 eats keep level=7.
- wall_hit in RUN with lives=3 -> state=4, lives=2, no step for 10 base_ticks. Then soft_reset pulse, state=1, level unchanged.
- Third death -> lives=0, state=5, game_over=1. start_btn -> lives=3, level=0, state=1, game_over=0.
- Same-cycle eat_evt+self_hit -> state=4, apple count unchanged. Reset asserted during DYING -> state=0 next cycle, all outputs at reset values.
- With SNAKE_PAUSE_EN: pause_btn in RUN after 6 of 10 divider base_ticks -> state=3, no step for any number of base_ticks. On resume, first step after 4 more base_ticks. Without SNAKE_PAUSE_EN: pause_btn -> state stays 2.

Source files
------------

// File: rtl/snake_game_seq.sv
// Snake game sequencer: start/countdown/run/pause/death/game-over FSM with lives and speed levels.
// Optional pause support is compiled in when SNAKE_PAUSE_EN is defined.
module snake_game_seq #(
    parameter int LIVES            = 3,
    parameter int DIV_START        = 10,
    parameter int DIV_STEP         = 1,
    parameter int DIV_MIN          = 3,
    parameter int APPLES_PER_LEVEL = 4,
    parameter int MAX_LEVEL        = 7,
    parameter int READY_TICKS      = 8,
    parameter int DIE_TICKS        = 10
) (
    input  logic       clk_pix,
    input  logic       reset,
    input  logic       base_tick,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       eat_evt,
    input  logic       self_hit,
    input  logic       wall_hit,
    output logic       step,
    output logic       soft_reset,
    output logic [2:0] state,
    output logic [3:0] lives,
    output logic [3:0] level,
    output logic       blink,
    output logic       game_over
);

    localparam int TICK_MAX = (READY_TICKS > DIE_TICKS) ? READY_TICKS : DIE_TICKS;
    localparam int TW       = $clog2(TICK_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DYING = 3'd4,
        ST_OVER  = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      lives_q, lives_d;
    logic [3:0]      level_q, level_d;
    logic [7:0]      apples_q, apples_d;
    logic [8:0]      div_q, div_d;
    logic [8:0]      period_q, period_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic            blink_q, blink_d;
    logic            step_q, step_d;
    logic            soft_reset_q, soft_reset_d;

    logic            hit;
    logic            pause_req;
    logic [8:0]      div_inc;
    logic [7:0]      apples_inc;
    logic [TW-1:0]   tick_inc;

    // Step period for a level, clamped to DIV_MIN instead of underflowing.
    function automatic logic [8:0] calc_period(input logic [3:0] lvl);
        logic [12:0] dec;
        dec = 13'(lvl) * 13'(DIV_STEP);
        if (dec >= 13'(DIV_START - DIV_MIN)) begin
            return 9'(DIV_MIN);
        end
        return 9'(DIV_START) - dec[8:0];
    endfunction

    assign hit        = self_hit | wall_hit;
    assign div_inc    = div_q + 9'd1;
    assign apples_inc = apples_q + 8'd1;
    assign tick_inc   = tick_q + TW'(1);

`ifdef SNAKE_PAUSE_EN
    assign pause_req = pause_btn;
`else
    logic unused_pause;
    assign pause_req    = 1'b0;
    assign unused_pause = pause_btn;
`endif

    // State register
    always_ff @(posedge clk_pix) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            state_q      <= ST_IDLE;
            lives_q      <= 4'(LIVES);
            level_q      <= 4'd0;
            apples_q     <= 8'd0;
            div_q        <= 9'd0;
            period_q     <= 9'(DIV_START);
            tick_q       <= '0;
            blink_q      <= 1'b0;
            step_q       <= 1'b0;
            soft_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            apples_q     <= apples_d;
            div_q        <= div_d;
            period_q     <= period_d;
            tick_q       <= tick_d;
            blink_q      <= blink_d;
            step_q       <= step_d;
            soft_reset_q <= soft_reset_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d      = state_q;
        lives_d      = lives_q;
        level_d      = level_q;
        apples_d     = apples_q;
        div_d        = div_q;
        period_d     = period_q;
        tick_d       = tick_q;
        blink_d      = blink_q;
        step_d       = 1'b0;
        soft_reset_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_btn) begin
                    state_d      = ST_READY;
                    lives_d      = 4'(LIVES);
                    level_d      = 4'd0;
                    apples_d     = 8'd0;
                    tick_d       = '0;
                    blink_d      = 1'b0;
                    soft_reset_d = 1'b1;
                end
            end

            ST_READY: begin
                if (base_tick) begin
                    if (tick_inc == TW'(READY_TICKS)) begin
                        state_d  = ST_RUN;
                        tick_d   = '0;
                        blink_d  = 1'b0;
                        div_d    = 9'd0;
                        period_d = calc_period(level_q);
                    end else begin
                        tick_d  = tick_inc;
                        blink_d = ~blink_q;
                    end
                end
            end

            ST_RUN: begin
                if (hit) begin
                    state_d = ST_DYING;
                    lives_d = (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;
                    tick_d  = '0;
                    blink_d = 1'b0;
                end else if (pause_req) begin
                    state_d = ST_PAUSE;
                end else begin
                    if (eat_evt) begin
                        if (apples_inc == 8'(APPLES_PER_LEVEL)) begin
                            apples_d = 8'd0;
                            if (level_q != 4'(MAX_LEVEL)) begin
                                level_d = level_q + 4'd1;
                            end
                        end else begin
                            apples_d = apples_inc;
                        end
                    end
                    // The period is latched at each step so a level-up only affects the next one.
                    if (base_tick) begin
                        if (div_inc >= period_q) begin
                            step_d   = 1'b1;
                            div_d    = 9'd0;
                            period_d = calc_period(level_d);
                        end else begin
                            div_d = div_inc;
                        end
                    end
                end
            end

`ifdef SNAKE_PAUSE_EN
            ST_PAUSE: begin
                if (pause_btn || start_btn) begin
                    state_d = ST_RUN;
                end
            end
`endif

            ST_DYING: begin
                if (base_tick) begin
                    if (tick_inc == TW'(DIE_TICKS)) begin
                        tick_d  = '0;
                        blink_d = 1'b0;
                        if (lives_q == 4'd0) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d      = ST_READY;
                            soft_reset_d = 1'b1;
                        end
                    end else begin
                        tick_d  = tick_inc;
                        blink_d = ~blink_q;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                tick_d  = '0;
                blink_d = 1'b0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        state      = state_q;
        lives      = lives_q;
        level      = level_q;
        blink      = blink_q;
        step       = step_q;
        soft_reset = soft_reset_q;
        game_over  = (state_q == ST_OVER);
    end

endmodule

// File: tb/tb_snake_game_seq.sv
// Self-checking bench for snake_game_seq; step periods are scored through an expected-value queue.
module tb_snake_game_seq;

    logic       clk_pix = 1'b0;
    logic       reset = 1'b1;
    logic       base_tick = 1'b0;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic       eat_evt = 1'b0;
    logic       self_hit = 1'b0;
    logic       wall_hit = 1'b0;
    logic       step;
    logic       soft_reset;
    logic [2:0] state;
    logic [3:0] lives;
    logic [3:0] level;
    logic       blink;
    logic       game_over;

    int passed = 0;
    int total = 0;
    int steps_seen = 0;
    int soft_cnt = 0;
    int exp_q[$];

    snake_game_seq dut (
        .clk_pix   (clk_pix),
        .reset     (reset),
        .base_tick (base_tick),
        .start_btn (start_btn),
        .pause_btn (pause_btn),
        .eat_evt   (eat_evt),
        .self_hit  (self_hit),
        .wall_hit  (wall_hit),
        .step      (step),
        .soft_reset(soft_reset),
        .state     (state),
        .lives     (lives),
        .level     (level),
        .blink     (blink),
        .game_over (game_over)
    );

    always #5 clk_pix = ~clk_pix;

    // step must only ever be seen while the block is in RUN
    always @(negedge clk_pix) begin
        if (step === 1'b1) begin
            total++;
            if (state !== 3'd2) $display("FAIL step_outside_run: state=%0d required=2", state);
            else passed++;
        end
    end

    task automatic cycle();
        @(posedge clk_pix);
        #1;
        if (step === 1'b1) steps_seen++;
        if (soft_reset === 1'b1) soft_cnt++;
    endtask

    task automatic tick(input int gap);
        base_tick = 1'b1;
        cycle();
        base_tick = 1'b0;
        repeat (gap) cycle();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick(3);
    endtask

    task automatic eat();
        eat_evt = 1'b1;
        cycle();
        eat_evt = 1'b0;
        cycle();
    endtask

    task automatic hit_cycle(input bit self);
        if (self) self_hit = 1'b1;
        else wall_hit = 1'b1;
        cycle();
        self_hit = 1'b0;
        wall_hit = 1'b0;
    endtask

    task automatic measure_period(input int exp_p, input int gap, input string name);
        int n;
        int s0;
        int got;
        int want;
        exp_q.push_back(exp_p);
        n = 0;
        s0 = steps_seen;
        while (steps_seen == s0 && n < 300) begin
            tick(gap);
            n++;
        end
        got = (steps_seen != s0) ? n : -1;
        want = exp_q.pop_front();
        total++;
        if (got !== want) $display("FAIL %s: step after %0d ticks, required %0d", name, got, want);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cycle();
        total++; if (state !== 3'd0) $display("FAIL rst_state: got %0d required 0", state); else passed++;
        total++; if (lives !== 4'd3) $display("FAIL rst_lives: got %0d required 3", lives); else passed++;
        total++; if (level !== 4'd0) $display("FAIL rst_level: got %0d required 0", level); else passed++;
        total++; if ({step, soft_reset, blink, game_over} !== 4'b0000)
            $display("FAIL rst_flags: got %b required 0000", {step, soft_reset, blink, game_over});
        else passed++;
        reset = 1'b0;
        cycle();
    endtask

    task automatic test_start();
        int s0;
        start_btn = 1'b1;
        cycle();
        start_btn = 1'b0;
        total++; if (soft_reset !== 1'b1) $display("FAIL start_soft: got %b required 1", soft_reset); else passed++;
        total++; if (state !== 3'd1) $display("FAIL start_state: got %0d required 1", state); else passed++;
        cycle();
        total++; if (soft_reset !== 1'b0) $display("FAIL start_soft_width: got %b required 0", soft_reset); else passed++;
        tick(3);
        total++; if (blink !== 1'b1) $display("FAIL ready_blink: got %b required 1", blink); else passed++;
        s0 = steps_seen;
        ticks(6);
        total++; if (state !== 3'd1) $display("FAIL ready_hold: got %0d required 1", state); else passed++;
        ticks(1);
        total++; if (state !== 3'd2) $display("FAIL ready_to_run: got %0d required 2", state); else passed++;
        total++; if (steps_seen - s0 !== 0) $display("FAIL ready_no_step: got %0d steps required 0", steps_seen - s0); else passed++;
        total++; if ({lives, level} !== {4'd3, 4'd0}) $display("FAIL run_lives_level: got %0d/%0d required 3/0", lives, level); else passed++;
    endtask

    task automatic test_levels();
        measure_period(10, 3, "p_lvl0");
        repeat (4) eat();
        total++; if (level !== 4'd1) $display("FAIL lvl1: got %0d required 1", level); else passed++;
        measure_period(10, 3, "p_inflight_lvl1");
        measure_period(9, 3, "p_lvl1");
        repeat (24) eat();
        total++; if (level !== 4'd7) $display("FAIL lvl7: got %0d required 7", level); else passed++;
        measure_period(9, 3, "p_inflight_lvl7");
        measure_period(3, 3, "p_lvl7");
        repeat (4) eat();
        total++; if (level !== 4'd7) $display("FAIL lvl_sat: got %0d required 7", level); else passed++;
    endtask

    task automatic test_back_to_back();
        measure_period(3, 0, "p_b2b_a");
        measure_period(3, 0, "p_b2b_b");
    endtask

    task automatic test_death();
        int s0;
        int c0;
        s0 = steps_seen;
        ticks(2);
        // hit in the same cycle as the period-completing tick
        base_tick = 1'b1;
        wall_hit = 1'b1;
        cycle();
        base_tick = 1'b0;
        wall_hit = 1'b0;
        total++; if (step !== 1'b0) $display("FAIL hit_suppress: got %b required 0", step); else passed++;
        total++; if (state !== 3'd4) $display("FAIL die_state: got %0d required 4", state); else passed++;
        total++; if (lives !== 4'd2) $display("FAIL die_lives: got %0d required 2", lives); else passed++;
        repeat (3) cycle();
        tick(3);
        total++; if (blink !== 1'b1) $display("FAIL die_blink: got %b required 1", blink); else passed++;
        ticks(8);
        total++; if (state !== 3'd4) $display("FAIL die_hold: got %0d required 4", state); else passed++;
        c0 = soft_cnt;
        ticks(1);
        total++; if (state !== 3'd1) $display("FAIL die_to_ready: got %0d required 1", state); else passed++;
        total++; if (soft_cnt - c0 !== 1) $display("FAIL die_soft: got %0d pulses required 1", soft_cnt - c0); else passed++;
        total++; if (level !== 4'd7) $display("FAIL die_level_kept: got %0d required 7", level); else passed++;
        total++; if (steps_seen - s0 !== 0) $display("FAIL die_no_step: got %0d steps required 0", steps_seen - s0); else passed++;
        ticks(8);
    endtask

    task automatic test_game_over();
        int c0;
        hit_cycle(1'b0);
        total++; if (lives !== 4'd1) $display("FAIL go_lives1: got %0d required 1", lives); else passed++;
        ticks(10);
        ticks(8);
        total++; if (state !== 3'd2) $display("FAIL go_rerun: got %0d required 2", state); else passed++;
        hit_cycle(1'b1);
        total++; if ({state, lives} !== {3'd4, 4'd0}) $display("FAIL go_last_hit: got %0d/%0d required 4/0", state, lives); else passed++;
        c0 = soft_cnt;
        ticks(10);
        total++; if (state !== 3'd5) $display("FAIL go_state: got %0d required 5", state); else passed++;
        total++; if ({game_over, blink} !== 2'b10) $display("FAIL go_flags: got %b required 10", {game_over, blink}); else passed++;
        total++; if (soft_cnt - c0 !== 0) $display("FAIL go_no_soft: got %0d pulses required 0", soft_cnt - c0); else passed++;
        start_btn = 1'b1;
        cycle();
        start_btn = 1'b0;
        total++; if ({state, soft_reset, game_over} !== {3'd1, 1'b1, 1'b0})
            $display("FAIL go_restart: got state=%0d soft=%b go=%b required 1/1/0", state, soft_reset, game_over);
        else passed++;
        total++; if ({lives, level} !== {4'd3, 4'd0}) $display("FAIL go_restart_lv: got %0d/%0d required 3/0", lives, level); else passed++;
        ticks(8);
    endtask

    task automatic test_eat_hit();
        repeat (3) eat();
        eat_evt = 1'b1;
        self_hit = 1'b1;
        cycle();
        eat_evt = 1'b0;
        self_hit = 1'b0;
        total++; if ({state, lives, level} !== {3'd4, 4'd2, 4'd0})
            $display("FAIL eat_hit: got %0d/%0d/%0d required 4/2/0", state, lives, level);
        else passed++;
        ticks(18);
        eat();
        total++; if (level !== 4'd1) $display("FAIL eat_hit_count: got %0d required 1", level); else passed++;
    endtask

    task automatic test_reset_dying();
        hit_cycle(1'b0);
        tick(3);
        total++; if ({state, blink} !== {3'd4, 1'b1}) $display("FAIL rd_pre: got %0d/%b required 4/1", state, blink); else passed++;
        reset = 1'b1;
        cycle();
        total++; if ({state, lives, level} !== {3'd0, 4'd3, 4'd0})
            $display("FAIL rd_regs: got %0d/%0d/%0d required 0/3/0", state, lives, level);
        else passed++;
        total++; if ({step, soft_reset, blink, game_over} !== 4'b0000)
            $display("FAIL rd_flags: got %b required 0000", {step, soft_reset, blink, game_over});
        else passed++;
        reset = 1'b0;
        cycle();
    endtask

    task automatic test_pause();
        int s0;
        start_btn = 1'b1;
        cycle();
        start_btn = 1'b0;
        ticks(8);
        s0 = steps_seen;
        ticks(6);
        pause_btn = 1'b1;
        cycle();
        pause_btn = 1'b0;
`ifdef SNAKE_PAUSE_EN
        total++; if (state !== 3'd3) $display("FAIL pause_state: got %0d required 3", state); else passed++;
        ticks(20);
        total++; if (state !== 3'd3) $display("FAIL pause_hold: got %0d required 3", state); else passed++;
        pause_btn = 1'b1;
        cycle();
        pause_btn = 1'b0;
        total++; if (state !== 3'd2) $display("FAIL pause_resume: got %0d required 2", state); else passed++;
`else
        total++; if (state !== 3'd2) $display("FAIL pause_ignored: got %0d required 2", state); else passed++;
`endif
        total++; if (steps_seen - s0 !== 0) $display("FAIL pause_no_step: got %0d steps required 0", steps_seen - s0); else passed++;
        measure_period(4, 3, "p_resume");
    endtask

    initial begin
        test_reset();
        test_start();
        test_levels();
        test_back_to_back();
        test_death();
        test_game_over();
        test_eat_hit();
        test_reset_dying();
        test_pause();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
